// File: rtl/mul_div.sv
// Multicycle multiply/divide unit driving the HILO write port.
// Multiplies and moves finish in one cycle; divides use a 32-step restoring loop.
module mul_div #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        annul_i,
  output logic        busy_o,
  output logic [1:0]  writeEnable_o,
  output logic [31:0] HI_data_o,
  output logic [31:0] LO_data_o
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DIV_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [1:0]      pend_q, pend_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               is_div;
  logic [31:0]        a_mag, b_mag;
  logic [32:0]        shifted, trial;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  assign is_div = (op_i == OP_DIV);
  assign a_mag  = (is_div && a_i[31]) ? -a_i : a_i;
  assign b_mag  = (is_div && b_i[31]) ? -b_i : b_i;

  // Remainder is always below the divisor, so 33 bits hold the shifted value.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    pend_d    = pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (annul_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            unique case (op_i)
              OP_MULT: begin
                {hi_d, lo_d} = prod_s;
                pend_d       = 2'b11;
                state_d      = S_DONE;
              end
              OP_MULTU: begin
                {hi_d, lo_d} = prod_u;
                pend_d       = 2'b11;
                state_d      = S_DONE;
              end
              OP_MTHI: begin
                hi_d    = a_i;
                pend_d  = 2'b10;
                state_d = S_DONE;
              end
              OP_MTLO: begin
                lo_d    = a_i;
                pend_d  = 2'b01;
                state_d = S_DONE;
              end
              OP_DIV, OP_DIVU: begin
                if (b_i == 32'd0) begin
                  lo_d    = 32'hFFFF_FFFF;
                  hi_d    = a_i;
                  pend_d  = 2'b11;
                  state_d = S_DONE;
                end else begin
                  quo_d     = a_mag;
                  dvs_d     = b_mag;
                  rem_d     = 32'd0;
                  cnt_d     = '0;
                  neg_quo_d = is_div && (a_i[31] ^ b_i[31]);
                  neg_rem_d = is_div && a_i[31];
                  state_d   = S_DIV_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        S_DIV_RUN: begin
          rem_d = trial[32] ? shifted[31:0] : trial[31:0];
          quo_d = {quo_q[30:0], ~trial[32]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_d = S_DIV_FIX;
        end
        S_DIV_FIX: begin
          lo_d    = neg_quo_q ? -quo_q : quo_q;
          hi_d    = neg_rem_q ? -rem_q : rem_q;
          pend_d  = 2'b11;
          state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      pend_q    <= 2'b00;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      pend_q    <= pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign writeEnable_o = (state_q == S_DONE && !annul_i) ? pend_q : 2'b00;
  assign HI_data_o     = hi_q;
  assign LO_data_o     = lo_q;

endmodule
